// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port unified memory of the multicycle CPU between the
// instruction-fetch requester and the load/store requester. One access is in
// flight at a time: the winner's address/data are registered, a single
// mem_en strobe is issued, the fixed memory latency is waited out, read data
// is captured into the winner's rdata register and a one-cycle ack returns.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   undefined -> fixed priority, data requester beats fetch requester
//   defined   -> a last-grant flag alternates the winner when both request
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    // WAIT lasts MEM_LATENCY-1 cycles, so the counter stops at MEM_LATENCY-2.
    // With a latency of 1 the WAIT state is skipped and this value is unused.
    localparam logic [3:0] WAIT_LAST = (MEM_LATENCY >= 2) ? 4'(MEM_LATENCY - 2) : 4'd0;

    logic [2:0]        state_q,    state_d;
    logic              grant_q,    grant_d;
    logic              we_q,       we_d;
    logic [3:0]        waitCnt_q,  waitCnt_d;
    logic [ADDR_W-1:0] memAddr_q,  memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              memEn_q;
    logic              memWe_q;
    logic              ifAck_q;
    logic              dAck_q;
    logic [DATA_W-1:0] ifRdata_q;
    logic [DATA_W-1:0] dRdata_q;
    logic              grantData;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastGrant_q;

    // Contested requests go to whoever was not served last; a lone request always wins.
    always_comb begin
        grantData = d_req;
        if (if_req && d_req) begin
            grantData = ~lastGrant_q;
        end
    end

    // Remember the winner of every grant taken in IDLE (0 = fetch, 1 = data).
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q <= 1'b0;
        end else if (state_q == IDLE && (if_req || d_req)) begin
            lastGrant_q <= grantData;
        end
    end
`else
    // Fixed priority: any pending data request beats a fetch request.
    always_comb begin
        grantData = d_req;
    end
`endif

    // Next-state logic: arbitrate and latch the winning request in IDLE, then step through the access.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        we_d       = we_q;
        waitCnt_d  = waitCnt_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = ISSUE;
                    grant_d = grantData;
                    if (grantData) begin
                        we_d       = d_we;
                        memAddr_d  = d_addr;
                        memWdata_d = d_wdata;
                    end else begin
                        we_d      = 1'b0;
                        memAddr_d = if_addr;
                    end
                end
            end
            ISSUE: begin
                waitCnt_d = 4'd0;
                state_d   = (MEM_LATENCY > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
                if (waitCnt_q == WAIT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    waitCnt_d = waitCnt_q + 4'd1;
                end
            end
            CAPTURE: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, memory strobes and acks are registered; strobes and acks are decoded from the next state
    // so they appear exactly during ISSUE and RESP respectively. Reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            waitCnt_q  <= 4'd0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            ifAck_q    <= 1'b0;
            dAck_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            waitCnt_q  <= waitCnt_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memEn_q    <= (state_d == ISSUE);
            memWe_q    <= (state_d == ISSUE) && we_d;
            ifAck_q    <= (state_d == RESP) && !grant_d;
            dAck_q     <= (state_d == RESP) && grant_d;
        end
    end

    // Read data lands in the granted requester's register in CAPTURE; stores leave d_rdata alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifRdata_q <= '0;
            dRdata_q  <= '0;
        end else if (state_q == CAPTURE && !we_q) begin
            if (grant_q) begin
                dRdata_q <= mem_rdata;
            end else begin
                ifRdata_q <= mem_rdata;
            end
        end
    end

    assign if_ack    = ifAck_q;
    assign d_ack     = dAck_q;
    assign if_rdata  = ifRdata_q;
    assign d_rdata   = dRdata_q;
    assign mem_en    = memEn_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Three arbiter instances with memory latencies 1, 3 and 4 share clock and
// reset; each has its own requesters and its own memory model. Directed
// scenarios cover fetch, load, store, contention, reset mid-access and
// back-to-back fetches. ARB_ROUND_ROBIN_EN selects the contention expectations.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cycleCnt = 0;

   logic [2:0]       ifReq, ifAck, dReq, dWe, dAck, memEn, memWe, busy, grantId;
   logic [2:0][31:0] ifAddr, ifRdata, dAddr, dWdata, dRdata, memAddr, memWdata, memRdata;

   logic [31:0] mem  [3][64];
   logic [31:0] pipe [3][4];

   int enCount [3];
   int enCycle [3];
   int enAddr  [3];
   int enWe    [3];
   int overlap [3];

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   // Free-running cycle index; during the cycle after posedge n it reads n.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : gDut
         mem_port_arbiter #(
            .ADDR_W(32),
            .DATA_W(32),
            .MEM_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
         ) dut (
            .clk(clk),
            .reset(reset),
            .if_req(ifReq[g]),
            .if_addr(ifAddr[g]),
            .if_ack(ifAck[g]),
            .if_rdata(ifRdata[g]),
            .d_req(dReq[g]),
            .d_we(dWe[g]),
            .d_addr(dAddr[g]),
            .d_wdata(dWdata[g]),
            .d_ack(dAck[g]),
            .d_rdata(dRdata[g]),
            .mem_en(memEn[g]),
            .mem_we(memWe[g]),
            .mem_addr(memAddr[g]),
            .mem_wdata(memWdata[g]),
            .mem_rdata(memRdata[g]),
            .busy(busy[g]),
            .grant_id(grantId[g])
         );
      end
   endgenerate

   function automatic int latOf(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
   endfunction

   function automatic logic [31:0] memInit(input int k, input int i);
      if (k == 0 && i == 4) return 32'hDEADBEEF;
      return 32'hC0DE0000 | 32'(k << 12) | 32'(i);
   endfunction

   // Memory model: word-indexed, refilled while reset is high. A read sampled
   // with mem_en enters a delay line; anything else pushes a poison word.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            for (int i = 0; i < 64; i++) mem[k][i] <= memInit(k, i);
         end else if (memEn[k] && memWe[k]) begin
            mem[k][memAddr[k][7:2]] <= memWdata[k];
         end
         pipe[k][0] <= (memEn[k] && !memWe[k]) ? mem[k][memAddr[k][7:2]] : 32'hBAD0BAD0;
         for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
      end
   end

   // The read word appears MEM_LATENCY edges after the sampling edge.
   always_comb begin
      for (int k = 0; k < 3; k++) memRdata[k] = pipe[k][latOf(k) - 1];
   end

   // Records memory strobes and any cycle where both acks are high.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (memEn[k]) begin
            enCount[k] = enCount[k] + 1;
            enCycle[k] = cycleCnt;
            enAddr[k]  = int'(memAddr[k]);
            enWe[k]    = int'(memWe[k]);
         end
         if (ifAck[k] && dAck[k]) overlap[k] = overlap[k] + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int k, input logic fReq, input logic [31:0] fAddr,
                                input logic dr, input logic we, input logic [31:0] da, input logic [31:0] wd);
      ifReq[k]  = fReq;
      ifAddr[k] = fAddr;
      dReq[k]   = dr;
      dWe[k]    = we;
      dAddr[k]  = da;
      dWdata[k] = wd;
   endtask

   task automatic waitAck(input int k, input logic isData, output int ackCycle);
      ackCycle = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (isData ? dAck[k] : ifAck[k]) begin
            ackCycle = cycleCnt;
            return;
         end
      end
      checkOutput("ack_timeout", 32'(ackCycle), 32'(k));
   endtask

   task automatic waitAny(input int k, output logic gotData, output int ackCycle);
      gotData  = 1'b0;
      ackCycle = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (ifAck[k] || dAck[k]) begin
            gotData  = dAck[k];
            ackCycle = cycleCnt;
            return;
         end
      end
      checkOutput("any_ack_timeout", 32'(ackCycle), 32'(k));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t, a, b, e0, ackCnt;
      int acks [3];
      logic gotD, expD;

      for (int k = 0; k < 3; k++) begin
         applyStimulus(k, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
         enCount[k] = 0; enCycle[k] = 0; enAddr[k] = 0; enWe[k] = 0; overlap[k] = 0;
      end

      // Reset state of every instance
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checkOutput("rst_busy",    32'(busy[k]),  32'h0);
         checkOutput("rst_mem_en",  32'(memEn[k]), 32'h0);
         checkOutput("rst_acks",    32'({ifAck[k], dAck[k]}), 32'h0);
         checkOutput("rst_if_rdata", ifRdata[k], 32'h0);
         checkOutput("rst_d_rdata",  dRdata[k],  32'h0);
         checkOutput("rst_mem_addr", memAddr[k], 32'h0);
      end
      reset = 1'b0;
      @(negedge clk);

      // 1: single fetch, latency 1
      t = cycleCnt;
      applyStimulus(0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
      waitAck(0, 1'b0, a);
      ifReq[0] = 1'b0;
      checkOutput("t1_ack_latency", 32'(a - t), 32'd3);
      checkOutput("t1_no_d_ack",    32'(dAck[0]), 32'h0);
      checkOutput("t1_if_rdata",    ifRdata[0], 32'hDEADBEEF);
      checkOutput("t1_en_cycle",    32'(enCycle[0] - t), 32'd1);
      checkOutput("t1_en_addr",     32'(enAddr[0]), 32'h10);
      checkOutput("t1_en_count",    32'(enCount[0]), 32'd1);

      // 2: load then store, latency 3
      @(negedge clk);
      t = cycleCnt;
      applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
      waitAck(1, 1'b1, a);
      dReq[1] = 1'b0;
      checkOutput("t2_load_latency", 32'(a - t), 32'd5);
      checkOutput("t2_load_rdata",   dRdata[1], memInit(1, 32));
      @(negedge clk);
      t  = cycleCnt;
      e0 = enCount[1];
      applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234);
      waitAck(1, 1'b1, a);
      dReq[1] = 1'b0;
      checkOutput("t2_store_latency", 32'(a - t), 32'd5);
      checkOutput("t2_store_rdata",   dRdata[1], memInit(1, 32));
      checkOutput("t2_store_pulses",  32'(enCount[1] - e0), 32'd1);
      checkOutput("t2_store_we",      32'(enWe[1]), 32'd1);
      checkOutput("t2_store_mem",     mem[1][16], 32'h1234);

      // 3: simultaneous fetch and load, latency 1; data is served first
      @(negedge clk);
      t = cycleCnt;
      applyStimulus(0, 1'b1, 32'h30, 1'b1, 1'b0, 32'h14, 32'h0);
      waitAck(0, 1'b1, a);
      dReq[0] = 1'b0;
      checkOutput("t3_d_ack_cycle",  32'(a - t), 32'd3);
      checkOutput("t3_d_grant_id",   32'(grantId[0]), 32'd1);
      checkOutput("t3_d_rdata",      dRdata[0], memInit(0, 5));
      checkOutput("t3_if_ack_low",   32'(ifAck[0]), 32'd0);
      waitAck(0, 1'b0, b);
      ifReq[0] = 1'b0;
      checkOutput("t3_if_ack_cycle", 32'(b - t), 32'd7);
      checkOutput("t3_if_rdata",     ifRdata[0], memInit(0, 12));

      // 4: both requesters keep requesting; four grants
      @(negedge clk);
      applyStimulus(0, 1'b1, 32'h34, 1'b1, 1'b0, 32'h18, 32'h0);
      for (int i = 0; i < 4; i++) begin
         waitAny(0, gotD, a);
`ifdef ARB_ROUND_ROBIN_EN
         expD = (i % 2 == 0);
`else
         expD = 1'b1;
`endif
         checkOutput("t4_grant_order", 32'(gotD), 32'(expD));
         if (gotD) checkOutput("t4_d_rdata",  dRdata[0],  memInit(0, 6));
         else      checkOutput("t4_if_rdata", ifRdata[0], memInit(0, 13));
      end
      ifReq[0] = 1'b0;
      dReq[0]  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t4_idle_after", 32'(busy[0]), 32'd0);

      // 5: reset during WAIT, latency 4
      t = cycleCnt;
      applyStimulus(2, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      checkOutput("t5_busy_in_wait", 32'(busy[2]), 32'd1);
      reset    = 1'b1;
      ifReq[2] = 1'b0;
      @(negedge clk);
      checkOutput("t5_busy_after_rst",   32'(busy[2]),  32'd0);
      checkOutput("t5_mem_en_after_rst", 32'(memEn[2]), 32'd0);
      reset  = 1'b0;
      ackCnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (ifAck[2] || dAck[2]) ackCnt++;
      end
      checkOutput("t5_no_ack", 32'(ackCnt), 32'd0);
      t = cycleCnt;
      applyStimulus(2, 1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0);
      waitAck(2, 1'b0, a);
      ifReq[2] = 1'b0;
      checkOutput("t5_recover_latency", 32'(a - t), 32'd6);
      checkOutput("t5_recover_rdata",   ifRdata[2], memInit(2, 9));

      // 6: back-to-back fetches, request re-raised right after each ack
      @(negedge clk);
      t = cycleCnt;
      applyStimulus(0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         waitAck(0, 1'b0, acks[i]);
         checkOutput("t6_rdata", ifRdata[0], memInit(0, i));
         if (i < 2) ifAddr[0] = 32'(4 * (i + 1));
         else       ifReq[0]  = 1'b0;
      end
      checkOutput("t6_first_latency", 32'(acks[0] - t), 32'd3);
      checkOutput("t6_gap_1", 32'(acks[1] - acks[0]), 32'd4);
      checkOutput("t6_gap_2", 32'(acks[2] - acks[1]), 32'd4);

      checkOutput("ack_overlap", 32'(overlap[0] + overlap[1] + overlap[2]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
